matmul_sched: RTL and testbench

MATMUL_SCHED -- requirements
Module: matmul_sched

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_rr_arb.sv | 38 +++
 rtl/matmul_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_matmul_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and small helpers for the matrix-multiply job scheduler.
package matmul_pkg;

    localparam int MAT_DIM   = 8;
    localparam int ELEM_W    = 8;
    localparam int RES_W     = 16;
    localparam int OP_W      = MAT_DIM * MAT_DIM * ELEM_W;
    localparam int RES_BUS_W = MAT_DIM * MAT_DIM * RES_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } sched_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int id, input int n);
        return ((id + 1) >= n) ? 0 : (id + 1);
    endfunction

endpackage

// File: rtl/matmul_rr_arb.sv
// Round-robin selector: lowest requesting index at or above ptr, wrapping to index 0.
import matmul_pkg::*;

module matmul_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [NREQ-1:0] hi_s;
    logic [NREQ-1:0] cand_s;

    // Requesters at or above the pointer take priority over the wrapped ones.
    always_comb begin
        hi_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_s[i] = req[i] && (i >= int'(ptr));
        end
    end

    assign cand_s = (|hi_s) ? hi_s : req;

    // Isolate the lowest set candidate bit and encode its index.
    always_comb begin
        grant = cand_s & (~cand_s + LSB_ONE);
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | ({IDW{grant[i]}} & IDW'(i));
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Job scheduler sharing one 8x8 matrix-multiply engine among NREQ requesters, one job at a time.
// Optional engine-wait watchdog is built in when MATMUL_SCHED_TIMEOUT_EN is defined.
import matmul_pkg::*;

module matmul_sched #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OP_W-1:0]  req_a,
    input  logic [NREQ*OP_W-1:0]  req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [RES_BUS_W-1:0]  rsp_data,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [1:0]            eng_reuse,
    output logic [OP_W-1:0]       eng_a,
    output logic [OP_W-1:0]       eng_b,
    input  logic                  eng_done,
    input  logic [RES_BUS_W-1:0]  eng_result
);

    localparam int IDW = id_width(NREQ);
    localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    if ((NREQ < 2) || (NREQ > 4) || (TIMEOUT_CYC < 1)) begin : g_param_err
        $error("matmul_sched: unsupported NREQ or TIMEOUT_CYC");
    end

    sched_state_e         state_r;
    sched_state_e         state_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       ptr_s;
    logic [IDW-1:0]       id_r;
    logic [IDW-1:0]       id_s;
    logic [IDW-1:0]       win_idx_s;
    logic [NREQ-1:0]      win_oh_s;
    logic [NREQ-1:0]      id_oh_s;
    logic [NREQ-1:0]      req_ready_r;
    logic [NREQ-1:0]      req_ready_s;
    logic [NREQ-1:0]      rsp_valid_r;
    logic [NREQ-1:0]      rsp_valid_s;
    logic                 eng_start_r;
    logic                 eng_start_s;
    logic                 load_op_s;
    logic                 cap_done_s;
    logic                 cap_to_s;
    logic                 timeout_s;
    logic [OP_W-1:0]      sel_a_s;
    logic [OP_W-1:0]      sel_b_s;
    logic [OP_W-1:0]      eng_a_r;
    logic [OP_W-1:0]      eng_b_r;
    logic [RES_BUS_W-1:0] rsp_data_r;

    matmul_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (win_oh_s),
        .idx   (win_idx_s)
    );

    assign id_oh_s = LSB_ONE << id_r;

    // One-hot mux of the granted requester's operand slices.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = sel_a_s | ({OP_W{id_oh_s[i]}} & req_a[i*OP_W +: OP_W]);
            sel_b_s = sel_b_s | ({OP_W{id_oh_s[i]}} & req_b[i*OP_W +: OP_W]);
        end
    end

`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

    logic [CNTW-1:0] wait_cnt_r;
    logic            rsp_err_r;

    // Cycles spent waiting on the engine for the current job.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNTW'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == CNTW'(TIMEOUT_CYC - 1));

    // Error flag qualifying the held response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_err_r <= 1'b0;
        end else if (cap_done_s) begin
            rsp_err_r <= 1'b0;
        end else if (cap_to_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Next-state and one-cycle control decode for the job sequence.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        id_s        = id_r;
        req_ready_s = '0;
        rsp_valid_s = rsp_valid_r;
        eng_start_s = 1'b0;
        load_op_s   = 1'b0;
        cap_done_s  = 1'b0;
        cap_to_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_s        = win_idx_s;
                    req_ready_s = win_oh_s;
                    state_s     = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                load_op_s   = 1'b1;
                eng_start_s = 1'b1;
                state_s     = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    cap_done_s  = 1'b1;
                    rsp_valid_s = id_oh_s;
                    state_s     = ST_RESP;
                end else if (timeout_s) begin
                    cap_to_s    = 1'b1;
                    rsp_valid_s = id_oh_s;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (|(rsp_ready & id_oh_s)) begin
                    rsp_valid_s = '0;
                    ptr_s       = IDW'(wrap_inc(int'(id_r), NREQ));
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                rsp_valid_s = '0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer and registered handshake outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            id_r        <= '0;
            req_ready_r <= '0;
            rsp_valid_r <= '0;
            eng_start_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            id_r        <= id_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            eng_start_r <= eng_start_s;
        end
    end

    // Operands are captured on the accept cycle and held until the next job.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            eng_a_r <= '0;
            eng_b_r <= '0;
        end else if (load_op_s) begin
            eng_a_r <= sel_a_s;
            eng_b_r <= sel_b_s;
        end else begin
            eng_a_r <= eng_a_r;
            eng_b_r <= eng_b_r;
        end
    end

    // Result holding register: engine result on completion, zeros on timeout.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_data_r <= '0;
        end else if (cap_done_s) begin
            rsp_data_r <= eng_result;
        end else if (cap_to_s) begin
            rsp_data_r <= '0;
        end else begin
            rsp_data_r <= rsp_data_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign eng_start = eng_start_r;
    assign eng_reuse = 2'b00;
    assign eng_a     = eng_a_r;
    assign eng_b     = eng_b_r;

endmodule

// File: tb/tb_matmul_sched.sv
// Randomized self-checking bench for matmul_sched with a behavioural job-level reference model.
`timescale 1ns/1ps

module tb_matmul_sched;

    localparam int NREQ = 2;
    localparam int TO   = 64;
    localparam int OPW  = 512;
    localparam int RW   = 1024;

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_a = '0;
    logic [NREQ*OPW-1:0]  req_b = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready = '0;
    logic [RW-1:0]        rsp_data;
    logic                 rsp_err;
    logic                 eng_start;
    logic [1:0]           eng_reuse;
    logic [OPW-1:0]       eng_a;
    logic [OPW-1:0]       eng_b;
    logic                 eng_done = 1'b0;
    logic [RW-1:0]        eng_result = '0;

    int n_pass = 0;
    int n_checks = 0;

    // stimulus controls
    bit  gen_en = 1'b0;
    int  gen_pct = 0;
    int  ready_mode = 0;
    int  lat_force = 0;
    bit  eng_hang = 1'b0;
    int  eng_cnt = 0;
    logic [OPW-1:0] eng_op_a, eng_op_b;

    // per-step snapshots taken on the falling edge
    logic [NREQ-1:0] s_req_ready, s_rsp_valid;
    logic [RW-1:0]   s_rsp_data;
    logic            s_rsp_err, s_eng_start;

    // reference model state
    bit              in_flight = 1'b0;
    int              job_id = 0;
    int              exp_ptr = 0;
    int              n_start = 0;
    int              start_cyc = 0;
    int              cyc = 0;
    logic [RW-1:0]   exp_res;
    logic [OPW-1:0]  exp_a, exp_b;
    logic [NREQ-1:0] rv_prev = '0;
    int              grants[$];

    always #5 HCLK = ~HCLK;

    matmul_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_reuse  (eng_reuse),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (low 512 bits)", name, act[511:0], exp[511:0]);
        end
    endtask

    // C[r][c] = sum_k A[r][k]*B[k][c], row-major elements, 16-bit wrap
    function automatic logic [RW-1:0] matmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [RW-1:0] c;
        int s;
        c = '0;
        for (int r = 0; r < 8; r++) begin
            for (int col = 0; col < 8; col++) begin
                s = 0;
                for (int k = 0; k < 8; k++) begin
                    s += int'(a[8*(r*8+k) +: 8]) * int'(b[8*(k*8+col) +: 8]);
                end
                c[16*(r*8+col) +: 16] = s[15:0];
            end
        end
        return c;
    endfunction

    function automatic int rr(input int p, input logic [NREQ-1:0] v);
        int w;
        w = -1;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (v[(p + o) % NREQ]) w = (p + o) % NREQ;
        end
        return w;
    endfunction

    function automatic bit onehot0(input logic [NREQ-1:0] v);
        return (v & (v - NREQ'(1))) == '0;
    endfunction

    // Reference model: job-level expectations checked every cycle.
    always @(negedge HCLK) begin
        int w;
        int act;
        cyc++;
        if (!HRESETn) begin
            chk("reset_ctrl", RW'({req_ready, rsp_valid, rsp_err, eng_start}), '0);
            chk("reset_ops", RW'({eng_a, eng_b}), '0);
            chk("reset_rsp", rsp_data, '0);
            in_flight = 1'b0;
            exp_ptr = 0;
        end else begin
            chk("onehot", RW'({onehot0(req_ready), onehot0(rsp_valid)}), RW'(2'b11));
            chk("eng_reuse", RW'(eng_reuse), '0);
            if (req_ready != '0) begin
                w = rr(exp_ptr, rv_prev);
                act = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) act = i;
                chk("grant_when_idle", RW'(in_flight), '0);
                chk("grant_winner", RW'(req_ready), (w >= 0) ? RW'(1) << w : '0);
                job_id = (w >= 0) ? w : act;
                chk("grant_handshake", RW'(req_valid[job_id]), RW'(1));
                exp_a = req_a[job_id*OPW +: OPW];
                exp_b = req_b[job_id*OPW +: OPW];
                exp_res = matmul(exp_a, exp_b);
                in_flight = 1'b1;
                n_start = 0;
                grants.push_back(job_id);
            end
            if (eng_start) begin
                chk("start_once", RW'(in_flight && (n_start == 0)), RW'(1));
                chk("eng_a", RW'(eng_a), RW'(exp_a));
                chk("eng_b", RW'(eng_b), RW'(exp_b));
                n_start++;
                start_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                chk("rsp_in_job", RW'(in_flight && (n_start == 1)), RW'(1));
                chk("rsp_valid_id", RW'(rsp_valid), RW'(1) << job_id);
                if (eng_hang) begin
                    chk("timeout_err", RW'(rsp_err), RW'(1));
                    chk("timeout_data", rsp_data, '0);
                    chk("timeout_latency", RW'(cyc - start_cyc), RW'(TO + 1));
                end else begin
                    chk("rsp_data", rsp_data, exp_res);
                    chk("rsp_err", RW'(rsp_err), '0);
                end
                if (rsp_ready[job_id]) begin
                    in_flight = 1'b0;
                    exp_ptr = (job_id + 1) % NREQ;
                end
            end
        end
        rv_prev = req_valid;
    end

    task automatic new_job(input int i);
        for (int w = 0; w < OPW / 32; w++) begin
            req_a[i*OPW + w*32 +: 32] = $urandom;
            req_b[i*OPW + w*32 +: 32] = $urandom;
        end
        req_valid[i] = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge HCLK);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_rsp_err   = rsp_err;
        s_eng_start = eng_start;
        if (eng_start) begin
            eng_cnt  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 8));
            eng_op_a = eng_a;
            eng_op_b = eng_b;
        end
        acc = req_ready & req_valid;
        @(posedge HCLK);
        #1;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_hang) begin
                eng_done   = 1'b1;
                eng_result = matmul(eng_op_a, eng_op_b);
            end
        end
        req_valid = req_valid & ~acc;
        if (gen_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && (int'($urandom_range(0, 99)) < gen_pct)) new_job(i);
            end
        end
        case (ready_mode)
            0: rsp_ready = '1;
            1: rsp_ready = NREQ'($urandom);
            default: rsp_ready = '0;
        endcase
    endtask

    task automatic wait_rsp(input logic [NREQ-1:0] mask, input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (((s_rsp_valid & mask) == '0) && (n < budget));
        chk(name, RW'((s_rsp_valid & mask) != '0), RW'(1));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        gen_en = 1'b0;
        ready_mode = 0;
        while (((req_valid != '0) || in_flight) && (n < 400)) begin
            step();
            n++;
        end
        chk(name, RW'((req_valid == '0) && !in_flight), RW'(1));
        repeat (3) step();
    endtask

    task automatic do_reset(input int n);
        HRESETn = 1'b0;
        repeat (n) step();
        HRESETn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] lit;
        logic [RW-1:0] d0;
        bit bad;
        int rdy_cnt;
        int st_cnt;
        int n;

        ready_mode = 0;
        do_reset(3);
        step();
        chk("reset_state", RW'({s_req_ready, s_rsp_valid, s_rsp_err, s_eng_start}), '0);

        // single job: identity times B[k]=k must return k in every element
        for (int k = 0; k < 64; k++) begin
            req_a[k*8 +: 8] = ((k / 8) == (k % 8)) ? 8'd1 : 8'd0;
            req_b[k*8 +: 8] = 8'(k);
            lit[k*16 +: 16] = 16'(k);
        end
        req_valid[0] = 1'b1;
        rdy_cnt = 0;
        st_cnt = 0;
        n = 0;
        do begin
            step();
            n++;
            if (s_req_ready[0]) rdy_cnt++;
            if (s_eng_start) st_cnt++;
        end while (!s_rsp_valid[0] && (n < 40));
        chk("single_ready_pulses", RW'(rdy_cnt), RW'(1));
        chk("single_start_pulses", RW'(st_cnt), RW'(1));
        chk("single_rsp_valid", RW'(s_rsp_valid), RW'(2'b01));
        chk("single_rsp_data", s_rsp_data, lit);
        chk("single_rsp_err", RW'(s_rsp_err), '0);
        repeat (3) step();

        // spurious engine completion while idle
        eng_done = 1'b1;
        eng_result = {32{$urandom}};
        bad = 1'b0;
        repeat (6) begin
            step();
            bad |= (s_rsp_valid != '0) || (s_req_ready != '0);
        end
        chk("spurious_done_idle", RW'(bad), '0);

        // contention from ptr=0: service order 0,1,0,1
        do_reset(2);
        grants.delete();
        new_job(0);
        new_job(1);
        gen_en = 1'b1;
        gen_pct = 100;
        n = 0;
        while ((grants.size() < 4) && (n < 200)) begin
            step();
            n++;
        end
        chk("contention_count", RW'(grants.size() >= 4), RW'(1));
        for (int i = 0; i < 4; i++) begin
            chk("contention_order", RW'((i < grants.size()) ? grants[i] : -1), RW'(i % 2));
        end
        drain("drain_contention");

        // backpressure: response held for 10 cycles, no new grant meanwhile
        ready_mode = 2;
        new_job(0);
        wait_rsp(2'b01, 40, "bp_rsp_seen");
        d0 = s_rsp_data;
        new_job(1);
        bad = 1'b0;
        repeat (10) begin
            step();
            bad |= (s_rsp_valid != 2'b01) || (s_rsp_data != d0) || (s_req_ready != '0);
        end
        chk("bp_hold", RW'(bad), '0);
        drain("drain_bp");

        // reset three cycles after eng_start; the late eng_done must be ignored
        lat_force = 20;
        new_job(0);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_eng_start && (n < 20));
        chk("rst_start_seen", RW'(s_eng_start), RW'(1));
        repeat (3) step();
        HRESETn = 1'b0;
        step();
        chk("rst_mid_ctrl", RW'({s_req_ready, s_rsp_valid, s_rsp_err, s_eng_start}), '0);
        chk("rst_mid_data", s_rsp_data, '0);
        step();
        HRESETn = 1'b1;
        lat_force = 0;
        bad = 1'b0;
        repeat (25) begin
            step();
            bad |= (s_rsp_valid != '0) || (s_req_ready != '0);
        end
        chk("rst_no_rsp", RW'(bad), '0);

        // randomized traffic with random backpressure
        gen_en = 1'b1;
        gen_pct = 30;
        ready_mode = 1;
        repeat (1500) step();
        drain("drain_random");

`ifdef MATMUL_SCHED_TIMEOUT_EN
        eng_hang = 1'b1;
        new_job(1);
        wait_rsp(2'b10, 120, "timeout_rsp_seen");
        chk("timeout_lit_err", RW'(s_rsp_err), RW'(1));
        chk("timeout_lit_data", s_rsp_data, '0);
        step();
        eng_hang = 1'b0;
        drain("drain_timeout");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
